// File: rtl/hdlc_pkg.sv
// hdlc_pkg: shared constants, state encoding and CRC helper for the HDLC receiver.
package hdlc_pkg;

    localparam logic [7:0]  HDLC_FLAG = 8'h7E;
    localparam logic [15:0] CRC_POLY  = 16'h1021;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } hdlc_state_e;

    // Bit positions inside frame_err
    localparam int ERR_ABORT = 0;
    localparam int ERR_ALIGN = 1;
    localparam int ERR_LEN   = 2;
    localparam int ERR_FCS   = 3;

    // One MSB-first CRC-16-CCITT step for a single data bit
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/hdlc_crc16.sv
// hdlc_crc16: bit-serial CRC-16-CCITT register with synchronous clear and enable.
module hdlc_crc16
    import hdlc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    // CRC register: clear to the init value, otherwise shift one data bit in when enabled
    always_ff @(posedge clk) begin
        if (!rst) begin
            crc <= CRC_INIT;
        end else if (clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc16_step(crc, din);
        end else begin
            crc <= crc;
        end
    end

endmodule

// File: rtl/hdlc_rx_frame.sv
// hdlc_rx_frame: HDLC receiver with flag/abort detection, zero-bit destuffing,
// length/alignment checks and a byte hold buffer that hides the FCS bytes.
// Optional feature macro: HDLC_RX_FCS_EN (CRC-16 FCS check, 3-byte hold buffer).
module hdlc_rx_frame
    import hdlc_pkg::*;
#(
    parameter int MAX_BYTES = 64,
    parameter int MIN_BYTES = 3,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_bit,
    input  logic             rx_en,
    input  logic             is_send,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [3:0]       frame_err,
    output logic [LEN_W-1:0] frame_len,
    output logic             is_recive
);

`ifdef HDLC_RX_FCS_EN
    localparam int HOLD_D = 3;
`else
    localparam int HOLD_D = 1;
`endif
    localparam int BC_W = $clog2(MAX_BYTES + 2);

    hdlc_state_e          state_r, state_s;
    logic [2:0]           ones_r, ones_s;
    logic [2:0]           bit_cnt_r, bit_cnt_s;
    logic [6:0]           sh_r, sh_s;
    logic [BC_W-1:0]      byte_cnt_r, byte_cnt_s;
    logic [2:0][7:0]      hold_r, hold_s;
    logic [1:0]           hold_cnt_r, hold_cnt_s;
    logic [LEN_W-1:0]     emit_cnt_r, emit_cnt_s;

    logic [7:0]           data_s;
    logic                 valid_s, last_s, done_s, ok_s, is_recive_s;
    logic [3:0]           err_s;
    logic [LEN_W-1:0]     len_s;
    logic [7:0]           byte_val_s;
    logic                 fcs_bad_s;

`ifdef HDLC_RX_FCS_EN
    logic [15:0]          crc_s;
    logic [15:0]          snap_r, snap_s;
    logic                 crc_clr_s, crc_en_s;

    hdlc_crc16 u_crc (
        .clk (clk),
        .rst (rst),
        .clr (crc_clr_s),
        .en  (crc_en_s),
        .din (rx_bit),
        .crc (crc_s)
    );
`endif

    // Bit decode, byte assembly, hold buffer and frame-close decisions
    always_comb begin
        state_s     = state_r;
        ones_s      = ones_r;
        bit_cnt_s   = bit_cnt_r;
        sh_s        = sh_r;
        byte_cnt_s  = byte_cnt_r;
        hold_s      = hold_r;
        hold_cnt_s  = hold_cnt_r;
        emit_cnt_s  = emit_cnt_r;
        data_s      = 8'h00;
        valid_s     = 1'b0;
        last_s      = 1'b0;
        done_s      = 1'b0;
        ok_s        = 1'b0;
        err_s       = 4'b0000;
        len_s       = {LEN_W{1'b0}};
        byte_val_s  = {sh_r, rx_bit};
`ifdef HDLC_RX_FCS_EN
        crc_clr_s   = 1'b0;
        crc_en_s    = 1'b0;
        snap_s      = snap_r;
        // Residue as it stood at the last byte boundary, before the flag bits
        fcs_bad_s   = (snap_r != 16'h0000);
`else
        fcs_bad_s   = 1'b0;
`endif

        if (is_send) begin
            // Local transmitter owns the line: drop any frame in progress
            if (state_r == DATA) begin
                done_s           = 1'b1;
                err_s[ERR_ABORT] = 1'b1;
                len_s            = emit_cnt_r;
            end else begin
                done_s = 1'b0;
            end
            state_s = HUNT;
        end else if (rx_en) begin
            if (rx_bit) begin
                ones_s = (ones_r == 3'd7) ? 3'd7 : ones_r + 3'd1;
            end else begin
                ones_s = 3'd0;
            end

            if (rx_bit && (ones_r == 3'd6)) begin
                // Seventh consecutive one: abort
                if (state_r == DATA) begin
                    done_s           = 1'b1;
                    err_s[ERR_ABORT] = 1'b1;
                    len_s            = emit_cnt_r;
                end else begin
                    done_s = 1'b0;
                end
                state_s = HUNT;
            end else if (!rx_bit && (ones_r == 3'd6)) begin
                // Flag: close any open frame, then resynchronise
                if (state_r == DATA) begin
                    err_s[ERR_ALIGN] = (bit_cnt_r != 3'd7);
                    err_s[ERR_LEN]   = (byte_cnt_r < BC_W'(MIN_BYTES));
                    err_s[ERR_FCS]   = fcs_bad_s;
                    ok_s             = (err_s == 4'b0000);
                    done_s           = 1'b1;
                    if (ok_s) begin
                        valid_s = 1'b1;
                        last_s  = 1'b1;
                        data_s  = hold_r[0];
                        len_s   = emit_cnt_r + LEN_W'(1);
                    end else begin
                        len_s   = emit_cnt_r;
                    end
                end else begin
                    done_s = 1'b0;
                end
                state_s    = SYNC;
                bit_cnt_s  = 3'd0;
                sh_s       = 7'd0;
                byte_cnt_s = {BC_W{1'b0}};
                hold_cnt_s = 2'd0;
                emit_cnt_s = {LEN_W{1'b0}};
`ifdef HDLC_RX_FCS_EN
                crc_clr_s  = 1'b1;
`endif
            end else if (!rx_bit && (ones_r == 3'd5)) begin
                // Stuffed zero carries no data
                sh_s = sh_r;
            end else if (state_r != HUNT) begin
                sh_s      = {sh_r[5:0], rx_bit};
                bit_cnt_s = bit_cnt_r + 3'd1;
`ifdef HDLC_RX_FCS_EN
                crc_en_s  = 1'b1;
                if (bit_cnt_r == 3'd0) begin
                    snap_s = crc_s;
                end else begin
                    snap_s = snap_r;
                end
`endif
                if (bit_cnt_r == 3'd7) begin
                    if (state_r == SYNC) begin
                        state_s    = DATA;
                        byte_cnt_s = BC_W'(1);
                        hold_s[0]  = byte_val_s;
                        hold_cnt_s = 2'd1;
                        emit_cnt_s = {LEN_W{1'b0}};
                    end else if (byte_cnt_r == BC_W'(MAX_BYTES)) begin
                        done_s         = 1'b1;
                        err_s[ERR_LEN] = 1'b1;
                        len_s          = emit_cnt_r;
                        hold_cnt_s     = 2'd0;
                        state_s        = HUNT;
                    end else begin
                        byte_cnt_s = byte_cnt_r + BC_W'(1);
                        if (hold_cnt_r == 2'(HOLD_D)) begin
                            // Buffer full: release the oldest byte, shift the new one in
                            valid_s           = 1'b1;
                            data_s            = hold_r[0];
                            emit_cnt_s        = emit_cnt_r + LEN_W'(1);
                            hold_s[0]         = hold_r[1];
                            hold_s[1]         = hold_r[2];
                            hold_s[HOLD_D-1]  = byte_val_s;
                        end else begin
                            for (int i = 0; i < HOLD_D; i++) begin
                                if (hold_cnt_r == 2'(i)) begin
                                    hold_s[i] = byte_val_s;
                                end else begin
                                    hold_s[i] = hold_s[i];
                                end
                            end
                            hold_cnt_s = hold_cnt_r + 2'd1;
                        end
                    end
                end else begin
                    byte_cnt_s = byte_cnt_r;
                end
            end else begin
                sh_s = sh_r;
            end
        end else begin
            state_s = state_r;
        end

        is_recive_s = (state_s == DATA);
    end

    // State, assemblers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= HUNT;
            ones_r     <= 3'd0;
            bit_cnt_r  <= 3'd0;
            sh_r       <= 7'd0;
            byte_cnt_r <= {BC_W{1'b0}};
            hold_r     <= {3{8'h00}};
            hold_cnt_r <= 2'd0;
            emit_cnt_r <= {LEN_W{1'b0}};
            m_data     <= 8'h00;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= 4'b0000;
            frame_len  <= {LEN_W{1'b0}};
            is_recive  <= 1'b0;
        end else begin
            state_r    <= state_s;
            ones_r     <= ones_s;
            bit_cnt_r  <= bit_cnt_s;
            sh_r       <= sh_s;
            byte_cnt_r <= byte_cnt_s;
            hold_r     <= hold_s;
            hold_cnt_r <= hold_cnt_s;
            emit_cnt_r <= emit_cnt_s;
            m_data     <= data_s;
            m_valid    <= valid_s;
            m_last     <= last_s;
            frame_done <= done_s;
            frame_ok   <= ok_s;
            frame_err  <= err_s;
            frame_len  <= len_s;
            is_recive  <= is_recive_s;
        end
    end

`ifdef HDLC_RX_FCS_EN
    // CRC snapshot taken at each byte boundary
    always_ff @(posedge clk) begin
        if (!rst) begin
            snap_r <= CRC_INIT;
        end else begin
            snap_r <= snap_s;
        end
    end
`endif

endmodule
